uart_rx: RTL and testbench

Serial receiver paired with `uart_tx` on the same 100 MHz fabric. Deserialises asynchronous 8-bit, LSB-first frames from the `RX` pin and emits each byte with a one-cycle valid strobe. Keeps a 4-byte shift buffer whose load order mirrors the transmitter's `TXBUF`, so a 4-byte automatic burst lands in identical slot positions. Accepts 1 or more stop bits, which covers `uart_tx`'s 2-stop-bit output.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_if.sv | 12 +
 rtl/uart_sync2.sv | 29 ++
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default line settings, framing levels and receiver states.
package uart_pkg;

  localparam int unsigned DEFAULT_CLOCK_FREQ = 32'd100000000;
  localparam int unsigned DEFAULT_BAUD_RATE  = 32'd115200;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver pin bundle: serial line in; decoded byte, strobes and shift buffer out.
interface uart_rx_if;
  logic            RX;
  logic [7:0]      RX_DATA;
  logic            RX_VALID;
  logic            FRAME_ERR;
  logic            BUSY;
  logic [3:0][7:0] RXBUF_OUT;

  modport master (output RX, input RX_DATA, RX_VALID, FRAME_ERR, BUSY, RXBUF_OUT);
  modport slave  (input RX, output RX_DATA, RX_VALID, FRAME_ERR, BUSY, RXBUF_OUT);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module uart_sync2
  import uart_pkg::*;
#(
  parameter logic RST_VAL = STOP_BIT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // metastability filter chain
  always_ff @(posedge CLK) begin
    if (RESET) begin
      meta_r <= RST_VAL;
      q_r    <= RST_VAL;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1+ UART receiver: centre-samples each bit, strobes good bytes and keeps a 4-byte shift buffer.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
  parameter int unsigned BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int unsigned BIT_TICKS  = CLOCK_FREQ / BAUD_RATE,
  parameter int unsigned HALF_TICKS = BIT_TICKS / 32'd2
) (
  input logic      CLK,
  input logic      RESET,
  uart_rx_if.slave bus
);

  localparam logic [15:0] BIT_LAST     = 16'(BIT_TICKS - 32'd1);
  localparam logic [15:0] HALF_LAST    = 16'(HALF_TICKS - 32'd1);
  localparam logic [3:0]  LAST_BIT_IDX = 4'd7;

  if (BIT_TICKS >= 32'd65536 || BIT_TICKS < 32'd4) begin : g_bad_ticks
    $error("uart_rx: BIT_TICKS must lie in [4, 65535]");
  end

  rx_state_t       state_r, state_s;
  logic [15:0]     cntr_r, cntr_s;
  logic [3:0]      bitcntr_r, bitcntr_s;
  logic [7:0]      shreg_r, shreg_s;
  logic            rx_sync_s, rx_prev_r;
  logic            good_s, bad_s;
  logic [7:0]      rx_data_r;
  logic            rx_valid_r, frame_err_r, busy_r;
  logic [3:0][7:0] rxbuf_r;

  uart_sync2 #(.RST_VAL(STOP_BIT)) u_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (bus.RX),
    .q     (rx_sync_s)
  );

  // FSM state and bit-timing counters
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r   <= IDLE;
      cntr_r    <= 16'd0;
      bitcntr_r <= 4'd0;
      shreg_r   <= 8'd0;
    end else begin
      state_r   <= state_s;
      cntr_r    <= cntr_s;
      bitcntr_r <= bitcntr_s;
      shreg_r   <= shreg_s;
    end
  end

  // next-state, sample points and end-of-frame verdict
  always_comb begin
    state_s   = state_r;
    cntr_s    = cntr_r + 16'd1;
    bitcntr_s = bitcntr_r;
    shreg_s   = shreg_r;
    good_s    = 1'b0;
    bad_s     = 1'b0;
    case (state_r)
      IDLE: begin
        cntr_s    = 16'd0;
        bitcntr_s = 4'd0;
        if (rx_sync_s == START_BIT && rx_prev_r == STOP_BIT) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cntr_r == HALF_LAST) begin
          cntr_s = 16'd0;
          // a line already high again at mid-start was a glitch
          if (rx_sync_s == START_BIT) begin
            state_s = DATA;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (cntr_r == BIT_LAST) begin
          cntr_s    = 16'd0;
          shreg_s   = {rx_sync_s, shreg_r[7:1]};
          bitcntr_s = bitcntr_r + 4'd1;
          if (bitcntr_r == LAST_BIT_IDX) begin
            state_s = STOP;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (cntr_r == BIT_LAST) begin
          cntr_s  = 16'd0;
          state_s = IDLE;
          if (rx_sync_s == STOP_BIT) begin
            good_s = 1'b1;
          end else begin
            bad_s = 1'b1;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s   = IDLE;
        cntr_s    = 16'd0;
        bitcntr_s = 4'd0;
      end
    endcase
  end

  // registered outputs, edge-detect history and receive buffer
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_prev_r   <= STOP_BIT;
      rx_data_r   <= 8'd0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
      rxbuf_r     <= 32'd0;
    end else begin
      rx_prev_r   <= rx_sync_s;
      rx_valid_r  <= good_s;
      frame_err_r <= bad_s;
      busy_r      <= (state_s != IDLE);
      if (good_s) begin
        rx_data_r <= shreg_r;
        rxbuf_r   <= {shreg_r, rxbuf_r[3:1]};
      end else begin
        rx_data_r <= rx_data_r;
        rxbuf_r   <= rxbuf_r;
      end
    end
  end

  assign bus.RX_DATA   = rx_data_r;
  assign bus.RX_VALID  = rx_valid_r;
  assign bus.FRAME_ERR = frame_err_r;
  assign bus.BUSY      = busy_r;
  assign bus.RXBUF_OUT = rxbuf_r;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised receiver bench: a sample-point model driven by the recorded line history predicts every output each cycle.
module tb_uart_rx;

  localparam int BIT  = 100;
  localparam int HALF = 50;

  logic clk = 1'b0;
  logic rst;
  uart_rx_if bus();

  uart_rx #(.CLOCK_FREQ(32'd10000000), .BAUD_RATE(32'd100000)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic hist [0:131071];

  // model state
  bit         checking = 1'b0;
  bit         m_active = 1'b0;
  int         m_det    = 0;
  logic [7:0] m_bits   = 8'd0;
  logic [7:0] m_good_q [$];
  logic       e_valid = 1'b0, e_ferr = 1'b0, e_busy = 1'b0;
  logic [7:0] e_data = 8'd0;

  // observed statistics
  int valid_cnt = 0, ferr_cnt = 0, busy_rises = 0;
  int last_valid_cyc = 0, busy_rise_cyc = 0, busy_fall_cyc = 0, edge_cyc = 0;
  logic busy_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, exp);
      if (n_fail >= 40) begin
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  endtask

  // newest good byte in slot 3, older ones below, zero where none yet
  function automatic logic [31:0] exp_buf();
    logic [31:0] r = 32'd0;
    for (int i = 0; i < 4; i++) begin
      int idx = m_good_q.size() - 4 + i;
      if (idx >= 0) r[i*8 +: 8] = m_good_q[idx];
    end
    return r;
  endfunction

  // bit k of a frame is read HALF + k*BIT cycles after the detect cycle
  function automatic void model_step(input int m);
    int off, k;
    e_valid = 1'b0;
    e_ferr  = 1'b0;
    if (m >= 2) begin
      if (!m_active) begin
        if (hist[m-1] == 1'b0 && hist[m-2] == 1'b1) begin
          m_active = 1'b1;
          m_det    = m;
        end
      end else begin
        off = m - m_det;
        if (off == HALF) begin
          if (hist[m-1] != 1'b0) m_active = 1'b0;
        end else if (off > HALF && (off - HALF) % BIT == 0) begin
          k = (off - HALF) / BIT;
          if (k <= 8) begin
            m_bits[k-1] = hist[m-1];
          end else begin
            m_active = 1'b0;
            if (hist[m-1] == 1'b1) begin
              e_valid = 1'b1;
              e_data  = m_bits;
              m_good_q.push_back(m_bits);
            end else begin
              e_ferr = 1'b1;
            end
          end
        end
      end
    end
    e_busy = m_active;
  endfunction

  // per-cycle monitor: record line, apply reset, compare, advance model
  always @(posedge clk) begin
    logic rs;
    hist[cyc] = bus.RX;
    rs = rst;
    #1;
    if (rs) begin
      m_active = 1'b0;
      m_good_q.delete();
      e_valid = 1'b0; e_ferr = 1'b0; e_busy = 1'b0; e_data = 8'd0;
      hist[cyc] = 1'b1;
      if (cyc >= 1) hist[cyc-1] = 1'b1;
      if (cyc >= 2) hist[cyc-2] = 1'b1;
      checking = 1'b1;
    end
    if (checking) begin
      check("outputs", {bus.RX_VALID, bus.FRAME_ERR, bus.BUSY, bus.RX_DATA, bus.RXBUF_OUT},
            {e_valid, e_ferr, e_busy, e_data, exp_buf()});
      if (bus.RX_VALID === 1'b1) begin valid_cnt++; last_valid_cyc = cyc; end
      if (bus.FRAME_ERR === 1'b1) ferr_cnt++;
      if (bus.BUSY === 1'b1 && !busy_prev) begin busy_rises++; busy_rise_cyc = cyc; end
      if (bus.BUSY === 1'b0 && busy_prev) busy_fall_cyc = cyc;
      busy_prev = bus.BUSY;
    end
    model_step(cyc);
    cyc++;
  end

  task automatic idle(input int n, input logic lvl = 1'b1);
    bus.RX = lvl;
    repeat (n) @(negedge clk);
  endtask

  // one frame at an arbitrary (fractional) bit period; call on a negedge
  task automatic send_frame(input logic [7:0] b, input int nstop, input real per, input logic stop_v);
    int n = 0;
    int tgt;
    logic v;
    for (int i = 0; i < 9 + nstop; i++) begin
      if (i == 0) v = 1'b0;
      else if (i <= 8) v = b[i-1];
      else v = stop_v;
      bus.RX = v;
      if (i == 0) edge_cyc = cyc;
      tgt = int'((i + 1) * per);
      while (n < tgt) begin @(negedge clk); n++; end
    end
  endtask

  initial begin
    int v0, f0, b0;
    real rates [2];
    logic [7:0] burst [4];
    rates[0] = 1.035; rates[1] = 0.965;
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44;
    bus.RX = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    idle(20);

    // single good frame, with literal latency pins
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1, real'(BIT), 1'b1);
    idle(60);
    check("a5_valid_count", valid_cnt - v0, 1);
    check("a5_ferr_count", ferr_cnt - f0, 0);
    check("a5_valid_latency", last_valid_cyc - edge_cyc, 952);
    check("a5_busy_rise", busy_rise_cyc - edge_cyc, 2);
    check("a5_data", bus.RX_DATA, 8'hA5);
    check("a5_buf", bus.RXBUF_OUT, 32'hA5000000);

    // 4-byte burst with two stop bits
    v0 = valid_cnt;
    for (int i = 0; i < 4; i++) send_frame(burst[i], 2, real'(BIT), 1'b1);
    idle(60);
    check("burst_valid_count", valid_cnt - v0, 4);
    check("burst_buf", bus.RXBUF_OUT, 32'h44332211);

    // framing error, line stays low, then returns high
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_rises;
    send_frame(8'h3C, 1, real'(BIT), 1'b0);
    idle(400, 1'b0);
    idle(100);
    check("ferr_count", ferr_cnt - f0, 1);
    check("ferr_no_valid", valid_cnt - v0, 0);
    check("ferr_no_retrigger", busy_rises - b0, 1);
    check("ferr_data_held", bus.RX_DATA, 8'h44);

    // short low glitch on the idle line
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_rises;
    idle(20, 1'b0);
    idle(100);
    check("glitch_busy_rise", busy_rises - b0, 1);
    check("glitch_busy_len", busy_fall_cyc - busy_rise_cyc, HALF);
    check("glitch_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 0);

    // reset in the middle of data bit 4
    fork
      send_frame(8'hFF, 1, real'(BIT), 1'b1);
      begin
        repeat (450) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_outputs", {bus.RX_VALID, bus.FRAME_ERR, bus.BUSY, bus.RX_DATA}, 11'd0);
        check("rst_buf", bus.RXBUF_OUT, 32'd0);
      end
    join
    idle(50);
    send_frame(8'h81, 1, real'(BIT), 1'b1);
    idle(60);
    check("post_rst_data", bus.RX_DATA, 8'h81);
    check("post_rst_buf", bus.RXBUF_OUT, 32'h81000000);

    // off-rate senders, zero gap
    for (int r = 0; r < 2; r++) begin
      send_frame(8'h55, 1, BIT / rates[r], 1'b1);
      send_frame(8'hAA, 1, BIT / rates[r], 1'b1);
      idle(100);
      check("rate_model_last", m_good_q[m_good_q.size()-1], 8'hAA);
      check("rate_model_prev", m_good_q[m_good_q.size()-2], 8'h55);
      check("rate_buf_top", bus.RXBUF_OUT[3:2], 16'hAA55);
    end

    // random frames: byte, stop count, baud skew, occasional bad stop, gap
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      real per;
      b   = 8'($urandom_range(0, 255));
      per = BIT / (1.0 + (real'($urandom_range(0, 60)) - 30.0) / 1000.0);
      send_frame(b, int'($urandom_range(1, 2)), per, ($urandom_range(0, 4) != 0));
      idle(int'($urandom_range(0, 30)));
    end
    idle(1200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "time limit");
  end

endmodule
